// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the frame accumulator and its output FIFO.
package fft_pkg;

    localparam int N_SAMPLES  = 16;
    localparam int IN_W       = 4;
    localparam int ACC_W      = 2 * IN_W + $clog2(N_SAMPLES);
    localparam int FIFO_DEPTH = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } fft_state_e;

endpackage

// File: rtl/fft_out_fifo.sv
// Two-entry result FIFO; head entry is presented combinationally, zero when empty.
module fft_out_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    import fft_pkg::*;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [FIFO_DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic do_push, do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees the head slot, so a push into a full FIFO is legal in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fft_frame_accumulator.sv
// Accumulates N_SAMPLES products a*b per frame at full precision and queues
// each frame sum in a two-entry output FIFO.
module fft_frame_accumulator #(
    parameter int  N_SAMPLES = fft_pkg::N_SAMPLES,
    parameter int  IN_W      = fft_pkg::IN_W,
    localparam int ACC_W     = 2 * IN_W + $clog2(N_SAMPLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_trunc,
    output logic [7:0]       frame_cnt
);
    import fft_pkg::*;

    localparam int CNT_W = $clog2(N_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_SAMPLES - 1);

    fft_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [ACC_W-1:0] product, push_data, head;
    logic             beat, last_beat, push, pop, fifo_full, fifo_empty;

    assign product   = ACC_W'(in_a) * ACC_W'(in_b);
    assign last_beat = (state_q == ACCUM) && (beat_cnt_q == LAST_BEAT);

    // Backpressure comes only from registered state, never from out_ready.
    assign in_ready  = !rst && !(last_beat && fifo_full);
    assign beat      = in_valid && in_ready;
    assign pop       = !fifo_empty && out_ready;

    assign out_valid = !fifo_empty;
    assign out_sum   = head;
    assign out_trunc = head[7:0];
    assign frame_cnt = frame_cnt_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beat_cnt_d  = beat_cnt_q;
        frame_cnt_d = frame_cnt_q;
        push        = 1'b0;
        push_data   = acc_q + product;
        if (clr) begin
            state_d    = IDLE;
            acc_d      = '0;
            beat_cnt_d = '0;
        end else if (beat) begin
            unique case (state_q)
                IDLE: begin
                    state_d    = ACCUM;
                    acc_d      = product;
                    beat_cnt_d = CNT_W'(1);
                end
                ACCUM: begin
                    if (last_beat) begin
                        push        = 1'b1;
                        state_d     = IDLE;
                        acc_d       = '0;
                        beat_cnt_d  = '0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        acc_d      = acc_q + product;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    fft_out_fifo #(
        .WIDTH(ACC_W)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (push_data),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_fft_frame_accumulator.sv
// Randomized and directed bench for fft_frame_accumulator against a queue-based
// frame model (partial sum, beat count, queued results, completed frames).
module tb_fft_frame_accumulator;
    import fft_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_a = '0;
    logic [IN_W-1:0]  in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_trunc;
    logic [7:0]       frame_cnt;

    int checks = 0;
    int failures = 0;

    int partSum = 0;
    int partCnt = 0;
    int frames = 0;
    int fifoQ[$];
    int delivered[$];

    always #5 clk = ~clk;

    fft_frame_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_trunc (out_trunc),
        .frame_cnt (frame_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        partSum = 0;
        partCnt = 0;
        frames  = 0;
        fifoQ.delete();
    endtask

    // One clock cycle: drive, compare outputs against the model mid-cycle, then advance the model.
    task automatic applyStimulus(input bit v, input int a, input int b, input bit rdy, input bit c,
                                 output bit accepted);
        int  aa, bb;
        bit  expReady, popNow;
        aa = a;
        bb = b;
        in_valid  = v;
        in_a      = aa[IN_W-1:0];
        in_b      = bb[IN_W-1:0];
        out_ready = rdy;
        clr       = c;
        @(negedge clk);
        expReady = !(partCnt == N_SAMPLES - 1 && fifoQ.size() == FIFO_DEPTH);
        popNow   = (fifoQ.size() > 0) && rdy;
        checkOutput("in_ready", 32'(in_ready), 32'(expReady));
        checkOutput("out_valid", 32'(out_valid), 32'(fifoQ.size() > 0));
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(frames % 256));
        if (fifoQ.size() > 0) begin
            checkOutput("out_sum", 32'(out_sum), 32'(fifoQ[0]));
            checkOutput("out_trunc", 32'(out_trunc), 32'(fifoQ[0] % 256));
        end
        if (popNow) delivered.push_back(int'(out_sum));
        accepted = v && expReady;
        @(posedge clk);
        #1;
        if (popNow) void'(fifoQ.pop_front());
        if (c) begin
            partSum = 0;
            partCnt = 0;
        end else if (accepted) begin
            partSum += a * b;
            partCnt++;
            if (partCnt == N_SAMPLES) begin
                fifoQ.push_back(partSum);
                frames++;
                partSum = 0;
                partCnt = 0;
            end
        end
    endtask

    task automatic runBeats(input string tag, input int n, input int a, input int b, input bit rdy);
        int  got;
        bit  acc;
        got = 0;
        for (int cyc = 0; cyc < 4 * n + 20 && got < n; cyc++) begin
            applyStimulus(1'b1, a, b, rdy, 1'b0, acc);
            if (acc) got++;
        end
        if (got != n) checkOutput(tag, 32'(got), 32'(n));
    endtask

    task automatic idleCycles(input int n, input bit rdy);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, rdy, 1'b0, acc);
    endtask

    task automatic checkDelivered(input string tag, input int exp[$]);
        checkOutput({tag, "_count"}, 32'(delivered.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < delivered.size(); i++)
            checkOutput(tag, 32'(delivered[i]), 32'(exp[i]));
        delivered.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_sum"}, 32'(out_sum), 32'd0);
        checkOutput({tag, "_out_trunc"}, 32'(out_trunc), 32'd0);
        checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int aR, bR;

        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();

        // Single frame 3*5 with a free-running consumer.
        runBeats("beats_3x5", N_SAMPLES, 3, 5, 1'b1);
        idleCycles(3, 1'b1);
        checkDelivered("sum_3x5", '{240});
        checkOutput("frames_after_3x5", 32'(frame_cnt), 32'd1);

        // Largest operands: full-precision sum exceeds 8 bits.
        runBeats("beats_15x15", N_SAMPLES, 15, 15, 1'b1);
        idleCycles(3, 1'b1);
        checkDelivered("sum_15x15", '{3600});

        // Stalled consumer: two results queue, third frame blocks on its last beat.
        runBeats("beats_stall", 2 * N_SAMPLES + N_SAMPLES - 1, 1, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1, 1, 1'b0, 1'b0, acc);
            checkOutput("stall_no_accept", 32'(acc), 32'd0);
        end
        runBeats("beats_unstall", 1, 1, 1, 1'b1);
        idleCycles(4, 1'b1);
        checkDelivered("sum_stall", '{16, 16, 16});

        // Aborted partial frame must not leak into the next result.
        runBeats("beats_pre_clr", 8, 2, 2, 1'b1);
        applyStimulus(1'b1, 7, 7, 1'b1, 1'b1, acc);
        runBeats("beats_post_clr", N_SAMPLES, 1, 2, 1'b1);
        idleCycles(3, 1'b1);
        checkDelivered("sum_clr", '{32});

        // Asynchronous reset on the 9th beat of a frame with one result queued.
        runBeats("beats_pre_rst", N_SAMPLES + 8, 3, 3, 1'b0);
        in_valid  = 1'b1;
        in_a      = IN_W'(3);
        in_b      = IN_W'(3);
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetOutputs("midrst");
        modelReset();
        delivered.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        runBeats("beats_4x4", N_SAMPLES, 4, 4, 1'b1);
        idleCycles(3, 1'b1);
        checkDelivered("sum_4x4", '{256});

        // Full FIFO drained while the final beat of a third frame waits.
        runBeats("beats_full1", N_SAMPLES, 1, 3, 1'b0);
        runBeats("beats_full2", N_SAMPLES, 2, 3, 1'b0);
        runBeats("beats_full3", N_SAMPLES - 1, 5, 7, 1'b0);
        runBeats("beats_full_last", 1, 5, 7, 1'b1);
        idleCycles(4, 1'b1);
        checkDelivered("sum_order", '{48, 96, 560});

        // Random traffic with occasional aborts.
        for (int i = 0; i < 600; i++) begin
            aR = int'($urandom_range(0, (1 << IN_W) - 1));
            bR = int'($urandom_range(0, (1 << IN_W) - 1));
            applyStimulus($urandom_range(0, 9) < 7, aR, bR, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 39) == 0, acc);
        end
        idleCycles(4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
